// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants, coordinate width and decoder FSM states
// Used by both the timing generator and vga_sync_decoder.
package vga_timing_pkg;

    localparam int COORD_W = 11;
    localparam logic [COORD_W-1:0] CNT_MAX = 11'd2047;

    // 640x480 @ 60 Hz, 25 MHz pixel clock
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 144;  // sync + back porch
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 35;   // sync + back porch
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_TOTAL  = 525;

    localparam int DEF_TOL         = 2;
    localparam int DEF_LOCK_FRAMES = 2;

    // Width of the polarity-detection period counters; must cover a full frame.
    localparam int POL_CNT_W = 20;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } dec_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - 2-FF synchronizer, edge register and leading-edge polarity select
// Optional feature macro: VGA_DEC_POLARITY_AUTO_EN (automatic sync polarity detection).
// Ports:
//   clk, rst    pixel clock, async active-high reset
//   sync_in     raw sync pin, asynchronous to clk
//   lead        one-cycle pulse on the sync leading edge
//   pol_change  one-cycle pulse when the detected polarity flips (always 0 without the macro)
module sync_edge_detect
    import vga_timing_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic lead,
    output logic pol_change
);

    logic s1;
    logic s2;
    logic s2_d;
    logic fall;

    // Reset to the idle level of an active-low sync so no edge appears at release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s2_d <= 1'b1;
        end else begin
            s1   <= sync_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign fall = s2_d & ~s2;

`ifdef VGA_DEC_POLARITY_AUTO_EN
    logic                 rise;
    logic                 pol;      // 0: active-low, 1: active-high
    logic                 pol_next;
    logic [POL_CNT_W-1:0] per_cnt;
    logic [POL_CNT_W-1:0] low_cnt;

    assign rise     = ~s2_d & s2;
    assign lead     = pol ? rise : fall;
    // A sync that sits low for most of its period is really an active-high pulse.
    assign pol_next = (low_cnt > (per_cnt >> 1));
    assign pol_change = lead & (pol_next != pol);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pol     <= 1'b0;
            per_cnt <= '0;
            low_cnt <= '0;
        end else if (lead) begin
            pol     <= pol_next;
            per_cnt <= POL_CNT_W'(1);
            low_cnt <= POL_CNT_W'(~s2);
        end else begin
            if (per_cnt != '1) begin
                per_cnt <= per_cnt + 1'b1;
            end
            if (!s2 && low_cnt != '1) begin
                low_cnt <= low_cnt + 1'b1;
            end
        end
    end
`else
    assign lead       = fall;
    assign pol_change = 1'b0;
`endif

endmodule

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - measures incoming VGA sync timing, locks to the mode, regenerates coordinates
// Optional feature macro: VGA_DEC_POLARITY_AUTO_EN (automatic sync polarity detection).
// Ports:
//   clk, rst      pixel clock, async active-high reset
//   hsync, vsync  raw syncs, asynchronous to clk
//   pixelx/y      registered coordinate inside the active window, else 0
//   active        registered: locked and inside the active window
//   locked        mode lock
//   line_len      last measured line period in clocks
//   frame_lines   hsync leading edges in the last complete frame
// Coordinates trail the sync pins by a fixed 3 clocks (2 sync FFs + output register).
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_BACK      = DEF_H_BACK,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int TOL         = DEF_TOL,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hsync,
    input  logic               vsync,
    output logic [COORD_W-1:0] pixelx,
    output logic [COORD_W-1:0] pixely,
    output logic               active,
    output logic               locked,
    output logic [COORD_W-1:0] line_len,
    output logic [COORD_W-1:0] frame_lines
);

    localparam logic [COORD_W-1:0] HB   = COORD_W'(H_BACK);
    localparam logic [COORD_W-1:0] HEND = COORD_W'(H_BACK + H_ACTIVE);
    localparam logic [COORD_W-1:0] VB   = COORD_W'(V_BACK);
    localparam logic [COORD_W-1:0] VEND = COORD_W'(V_BACK + V_ACTIVE);
    localparam logic [COORD_W-1:0] TOLV = COORD_W'(TOL);
    localparam logic [7:0]         LOCK_M1 = 8'(LOCK_FRAMES - 1);

    logic hs_lead;
    logic vs_lead;
    logic hs_pol_chg;
    logic vs_pol_chg;

    sync_edge_detect u_hs_edge (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (hsync),
        .lead       (hs_lead),
        .pol_change (hs_pol_chg)
    );

    sync_edge_detect u_vs_edge (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (vsync),
        .lead       (vs_lead),
        .pol_change (vs_pol_chg)
    );

    dec_state_t         state;
    dec_state_t         state_nxt;
    logic [COORD_W-1:0] hcnt;
    logic [COORD_W-1:0] vcnt;
    logic [COORD_W-1:0] lines_seen;
    logic [COORD_W-1:0] ref_len;
    logic [COORD_W-1:0] ref_lines;
    logic [COORD_W-1:0] len_diff;
    logic [7:0]         match_cnt;
    logic [7:0]         match_cnt_inc;
    logic               timeout;
    logic               mode_match;
    logic               load_ref;
    logic               clr_match;
    logic               inc_match;
    logic               in_window;

    assign timeout       = (hcnt == CNT_MAX) || (vcnt == CNT_MAX);
    assign len_diff      = (line_len >= ref_len) ? (line_len - ref_len) : (ref_len - line_len);
    // lines_seen still holds the frame just finished (the coincident hs_lead is not yet counted).
    assign mode_match    = (len_diff <= TOLV) && (lines_seen == ref_lines);
    assign match_cnt_inc = match_cnt + 8'd1;
    assign locked        = (state == ST_LOCKED);
    assign in_window     = (hcnt >= HB) && (hcnt < HEND) && (vcnt >= VB) && (vcnt < VEND);

    always_comb begin
        state_nxt = state;
        load_ref  = 1'b0;
        clr_match = 1'b0;
        inc_match = 1'b0;
        if (timeout) begin
            state_nxt = ST_SEARCH;
        end else if (hs_pol_chg || vs_pol_chg) begin
            state_nxt = ST_MEASURE;
            load_ref  = 1'b1;
            clr_match = 1'b1;
        end else if (vs_lead) begin
            case (state)
                ST_SEARCH: begin
                    state_nxt = ST_MEASURE;
                    load_ref  = 1'b1;
                    clr_match = 1'b1;
                end
                ST_MEASURE: begin
                    if (mode_match) begin
                        inc_match = 1'b1;
                        if (match_cnt_inc >= LOCK_M1) begin
                            state_nxt = ST_LOCKED;
                        end
                    end else begin
                        load_ref  = 1'b1;
                        clr_match = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!mode_match) begin
                        state_nxt = ST_MEASURE;
                        load_ref  = 1'b1;
                        clr_match = 1'b1;
                    end
                end
                default: state_nxt = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_SEARCH;
            hcnt        <= '0;
            vcnt        <= '0;
            line_len    <= '0;
            lines_seen  <= '0;
            frame_lines <= '0;
            ref_len     <= '0;
            ref_lines   <= '0;
            match_cnt   <= '0;
        end else begin
            state <= state_nxt;

            if (hs_lead) begin
                hcnt     <= '0;
                line_len <= hcnt + 1'b1;
            end else if (hcnt != CNT_MAX) begin
                hcnt <= hcnt + 1'b1;
            end

            if (vs_lead) begin
                vcnt <= '0;
            end else if (hs_lead && vcnt != CNT_MAX) begin
                vcnt <= vcnt + 1'b1;
            end

            if (vs_lead) begin
                frame_lines <= lines_seen;
                lines_seen  <= COORD_W'(hs_lead);
            end else if (hs_lead && lines_seen != CNT_MAX) begin
                lines_seen <= lines_seen + 1'b1;
            end

            if (load_ref) begin
                ref_len   <= line_len;
                ref_lines <= lines_seen;
            end

            if (clr_match) begin
                match_cnt <= '0;
            end else if (inc_match) begin
                match_cnt <= match_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixelx <= '0;
            pixely <= '0;
            active <= 1'b0;
        end else begin
            pixelx <= in_window ? (hcnt - HB) : '0;
            pixely <= in_window ? (vcnt - VB) : '0;
            active <= locked && in_window;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed self-checking bench for vga_sync_decoder on a reduced 40x20 raster
module tb_vga_sync_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync;
    logic        vsync;
    logic [10:0] pixelx;
    logic [10:0] pixely;
    logic        active;
    logic        locked;
    logic [10:0] line_len;
    logic [10:0] frame_lines;

    int n_cmp = 0;
    int n_bad = 0;

    // Probe points (line, drive index) inside a locked 40x20 frame; position seen = index - 4.
    int pl [6] = '{3, 3, 14, 15, 5, 9};
    int pj [6] = '{14, 13, 37, 20, 38, 25};
    int ex [6] = '{0, 0, 23, 0, 0, 11};
    int ey [6] = '{0, 0, 11, 0, 0, 6};
    int ea [6] = '{1, 0, 1, 0, 0, 1};

    vga_sync_decoder #(
        .H_BACK      (10),
        .H_ACTIVE    (24),
        .V_BACK      (3),
        .V_ACTIVE    (12),
        .TOL         (2),
        .LOCK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hsync       (hsync),
        .vsync       (vsync),
        .pixelx      (pixelx),
        .pixely      (pixely),
        .active      (active),
        .locked      (locked),
        .line_len    (line_len),
        .frame_lines (frame_lines)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_pixelx"}, 32'(pixelx), 0);
        check_eq({pfx, "_pixely"}, 32'(pixely), 0);
        check_eq({pfx, "_active"}, 32'(active), 0);
        check_eq({pfx, "_locked"}, 32'(locked), 0);
        check_eq({pfx, "_line_len"}, 32'(line_len), 0);
        check_eq({pfx, "_frame_lines"}, 32'(frame_lines), 0);
    endtask

    // hsync low for 4 clocks per line, vsync low for lines 0-1, both starting together.
    task automatic run_frame(input int lines, input int hlen, input bit probe, input int rst_line);
        for (int l = 0; l < lines; l++) begin
            for (int j = 0; j < hlen; j++) begin
                @(negedge clk);
                if (probe) begin
                    for (int p = 0; p < 6; p++) begin
                        if (pl[p] == l && pj[p] == j) begin
                            check_eq($sformatf("probe%0d_pixelx", p), 32'(pixelx), ex[p]);
                            check_eq($sformatf("probe%0d_pixely", p), 32'(pixely), ey[p]);
                            check_eq($sformatf("probe%0d_active", p), 32'(active), ea[p]);
                        end
                    end
                end
                if (l == rst_line && j == 20) begin
                    check_eq("pre_rst_active", 32'(active), 1);
                    check_eq("pre_rst_pixelx", 32'(pixelx), 6);
                    rst = 1'b1;
                    #1;
                    check_all_zero("mid_rst");
                end
                if (l == rst_line && j == 22) begin
                    rst = 1'b0;
                end
                hsync = (j < 4) ? 1'b0 : 1'b1;
                vsync = (l < 2) ? 1'b0 : 1'b1;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Lock acquisition: vs_lead 1 -> MEASURE, 2 -> mismatch reload, 3 -> LOCKED
        run_frame(20, 40, 1'b0, -1);
        run_frame(20, 40, 1'b0, -1);
        check_eq("f2_locked", 32'(locked), 0);
        check_eq("f2_line_len", 32'(line_len), 40);
        check_eq("f2_frame_lines", 32'(frame_lines), 20);
        run_frame(20, 40, 1'b1, -1);
        check_eq("f3_locked", 32'(locked), 1);
        check_eq("f3_line_len", 32'(line_len), 40);
        check_eq("f3_frame_lines", 32'(frame_lines), 20);

        // +/-2 clock jitter keeps lock
        run_frame(20, 42, 1'b0, -1);
        check_eq("jit_p2_line_len", 32'(line_len), 42);
        run_frame(20, 38, 1'b0, -1);
        check_eq("jit_p2_locked", 32'(locked), 1);
        run_frame(20, 40, 1'b0, -1);
        check_eq("jit_m2_locked", 32'(locked), 1);

        // +3 clock deviation drops lock, relock two frames later
        run_frame(20, 43, 1'b0, -1);
        run_frame(20, 40, 1'b0, -1);
        check_eq("jit_p3_drop", 32'(locked), 0);
        run_frame(20, 40, 1'b0, -1);
        check_eq("jit_p3_measure", 32'(locked), 0);
        run_frame(20, 40, 1'b0, -1);
        check_eq("jit_p3_relock", 32'(locked), 1);

        // Short frame of 19 lines
        run_frame(19, 40, 1'b0, -1);
        run_frame(20, 40, 1'b0, -1);
        check_eq("short_locked", 32'(locked), 0);
        check_eq("short_frame_lines", 32'(frame_lines), 19);
        run_frame(20, 40, 1'b0, -1);
        check_eq("short_measure", 32'(locked), 0);
        run_frame(20, 40, 1'b0, -1);
        check_eq("short_relock", 32'(locked), 1);

        // hsync stuck high: hcnt saturates and forces SEARCH
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (1900) @(negedge clk);
        check_eq("stuck_before_timeout", 32'(locked), 1);
        repeat (200) @(negedge clk);
        check_eq("stuck_locked", 32'(locked), 0);
        check_eq("stuck_active", 32'(active), 0);

        // Recover, then reset mid-frame and reacquire from scratch
        run_frame(20, 40, 1'b0, -1);
        run_frame(20, 40, 1'b0, -1);
        run_frame(20, 40, 1'b0, -1);
        run_frame(20, 40, 1'b0, 8);
        run_frame(20, 40, 1'b0, -1);
        run_frame(20, 40, 1'b0, -1);
        check_eq("post_rst_vs2_locked", 32'(locked), 0);
        run_frame(20, 40, 1'b0, -1);
        check_eq("post_rst_vs3_locked", 32'(locked), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: takes raw hsync/vsync (from a capture port or looped back from our own generator), measures line and frame timing, locks onto a stable mode, and regenerates pixelx/pixely/active aligned to the incoming syncs. It sits between the sync input pins and any pixel-capture or overlay logic that needs coordinates. It is also the self-check path for our generator.

## Interface
- H_BACK, 144: clocks from hsync leading edge to first active pixel (sync + back porch).
- H_ACTIVE, 640: active pixels per line.
- V_BACK, 35: lines from vsync leading edge to first active line.
- V_ACTIVE, 480: active lines per frame.
- TOL, 2: allowed line-period deviation (clocks) between frames while locked.
- LOCK_FRAMES, 2: consecutive matching frames required to assert locked.
- clk  in  1  pixel clock (25 MHz in the default mode).
- rst  in  1  asynchronous, active-high reset.
- hsync  in  1  raw horizontal sync, asynchronous to clk.
- vsync  in  1  raw vertical sync, asynchronous to clk.
- pixelx  out  11  hcnt − H_BACK inside the active window, else 0.
- pixely  out  11  vcnt − V_BACK inside the active window, else 0.
- active  out  1  locked and inside the active window.
- locked  out  1  mode lock.
- line_len  out  11  last measured line period in clocks.
- frame_lines  out  11  hsync leading edges counted in the last complete frame.

## Operation
- Each sync passes through a 2-FF synchronizer and a 1-FF edge detector. The leading edge is high→low (active-low pulse) unless polarity detection is enabled.
- hcnt (11 b): cleared on hs_lead, else increments. Saturates at 2047. Reaching 2047 is a timeout and forces SEARCH.
- On hs_lead: line_len <= hcnt+1.
- vcnt (11 b): cleared on vs_lead, else increments on hs_lead. vs_lead wins when both occur in the same cycle. Saturates at 2047. Reaching 2047 is a timeout and forces SEARCH.
- lines_seen counts hs_lead since the last vs_lead.
  - On vs_lead: frame_lines <= lines_seen (excluding a simultaneous hs_lead), then lines_seen <= hs_lead ? 1 : 0.
- FSM states are SEARCH, MEASURE and LOCKED. Mode compare happens at each vs_lead.
  - SEARCH: on first vs_lead, store ref_len/ref_lines from current measurements, match_cnt <= 0, go to MEASURE.
  - MEASURE: on vs_lead, a match is |line_len − ref_len| ≤ TOL and frame_lines == ref_lines.
    - Match: match_cnt++. When match_cnt reaches LOCK_FRAMES−1, go to LOCKED.
    - Mismatch: reload the ref registers, match_cnt <= 0.
  - LOCKED: on vs_lead mismatch, go to MEASURE, reload the ref registers, match_cnt <= 0. Match stays LOCKED.
  - Any state: timeout goes to SEARCH.
- locked = (state == LOCKED).
- active = locked & H_BACK ≤ hcnt < H_BACK+H_ACTIVE & V_BACK ≤ vcnt < V_BACK+V_ACTIVE.
- Widths: all subtraction is 11-bit unsigned and only evaluated inside the window, so there is no wrap.

## Timing
- Reset values: pixelx=0, pixely=0, active=0, locked=0, line_len=0, frame_lines=0; state=SEARCH; hcnt=vcnt=0.
- Reset asserted mid-frame clears everything immediately (async). Lock requires a fresh SEARCH→MEASURE→LOCKED sequence.
- Latency: a sync leading edge sampled at clk edge N yields hcnt==0 (and vcnt==0 for vsync) in the cycle following edge N+2.
- Outputs are registered from counters, adding one further cycle.
- Downstream logic must compensate for this fixed 3-cycle offset.
- Lock: with clean input, locked asserts in the cycle after the (LOCK_FRAMES+1)-th vs_lead, counted from reset release.
- locked drops in the cycle after the offending vs_lead or the timeout cycle.

## Configuration
- VGA_DEC_POLARITY_AUTO_EN:
  - Defined: per sync, count low clocks between leading edges. If low time exceeds half the period, treat the sync as active-high (leading edge low→high).
  - A polarity change forces MEASURE.
  - Polarity resets to active-low.
- Undefined: both syncs are fixed active-low and the polarity logic is absent.

## Structure
- Package vga_timing_pkg: default timing constants (H/V back, active, total), the FSM state typedef and the 11-bit coordinate width.
- The generator module shares the same package.
- Sub-module sync_edge_detect handles the 2-FF synchronizer, edge register and polarity select. It is instantiated once per sync.

## Test plan
- Loopback, 640x480 from the generator (800 clk/line, 525 lines): line_len=800, frame_lines=525, locked after the 3rd vs_lead. The first active cycle shows pixelx=0, pixely=0 at hcnt=144, vcnt=35.
- Line jitter of ±2 clocks while locked: locked stays 1. A ±3-clock deviation drops locked at that vs_lead and relocks 2 frames later.
- Frame of 524 lines injected while locked: locked=0 after that vs_lead, frame_lines=524.
- hsync stuck high while locked: hcnt reaches 2047, state goes to SEARCH, locked=0, active=0.
- rst pulse mid-frame: all outputs are 0 the same cycle, and lock returns only after 3 vs_leads.
- With VGA_DEC_POLARITY_AUTO_EN, syncs inverted: the same line_len/frame_lines/lock as the first scenario, plus one extra MEASURE frame.
